// File: rtl/lt_sequencer.sv
`timescale 1ns / 1ps
// lt_sequencer: display latency-test controller. Arms on a start request,
// lights the test pattern from the next frame start, then times the
// photodiode: latency (frame start -> first light) and stabilisation time
// (first light -> start of the final stable-high window), in prescaled ticks.
module lt_sequencer #(
    parameter int unsigned PRESCALE   = 27,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned STB_WINDOW = 500
) (
    input  logic             i_clk27,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_abort,
    input  logic [1:0]       i_mode_in,
    input  logic             i_vsync_in,
    input  logic             i_sensor_in,
    output logic             o_lt_active,
    output logic [1:0]       o_lt_mode,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_timeout,
    output logic [CNT_W-1:0] o_result_lat,
    output logic [CNT_W-1:0] o_result_stb
);

    typedef enum logic [2:0] {StIdle, StWaitVs, StLat, StStb, StDone} state_t;

    localparam int unsigned      PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int unsigned      DW         = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [PW-1:0]    PresLast   = PW'(PRESCALE - 1);
    localparam logic [DW-1:0]    DbLast     = DW'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CntMax     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntNearMax = {{(CNT_W-1){1'b1}}, 1'b0};
    localparam logic [CNT_W-1:0] StbWin     = CNT_W'(STB_WINDOW);

    state_t           r_state;
    logic             r_vsync_q;
    logic             r_sens_s1;
    logic             r_sens_s2;
    logic             r_sensor_db;
    logic             r_db_rise;
    logic [DW-1:0]    r_db_cnt;
    logic [PW-1:0]    r_presc;
    logic [CNT_W-1:0] r_lat_cnt;
    logic [CNT_W-1:0] r_stb_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_lt_active;
    logic [1:0]       r_lt_mode;
    logic             r_done;
    logic             r_timeout;
    logic [CNT_W-1:0] r_result_lat;
    logic [CNT_W-1:0] r_result_stb;

    logic w_frame_start;
    logic w_run;
    logic w_tick;

    // VSYNC is active-low, so a frame begins on its falling edge
    assign w_frame_start = r_vsync_q && !i_vsync_in;
    assign w_run         = (r_state == StLat) || (r_state == StStb);
    assign w_tick        = w_run && (r_presc == PresLast);

    assign o_lt_active  = r_lt_active;
    assign o_lt_mode    = r_lt_mode;
    assign o_busy       = (r_state != StIdle);
    assign o_done       = r_done;
    assign o_timeout    = r_timeout;
    assign o_result_lat = r_result_lat;
    assign o_result_stb = r_result_stb;

    // Register VSYNC for edge detection
    always_ff @(posedge i_clk27) begin
        if (i_reset) begin
            r_vsync_q <= 1'b0;
        end else begin
            r_vsync_q <= i_vsync_in;
        end
    end

    // Synchronise the photodiode and accept a new level after DEBOUNCE equal samples;
    // r_db_rise pulses in the same cycle the debounced level goes high
    always_ff @(posedge i_clk27) begin
        if (i_reset) begin
            r_sens_s1   <= 1'b0;
            r_sens_s2   <= 1'b0;
            r_sensor_db <= 1'b0;
            r_db_cnt    <= '0;
            r_db_rise   <= 1'b0;
        end else begin
            r_sens_s1 <= i_sensor_in;
            r_sens_s2 <= r_sens_s1;
            r_db_rise <= 1'b0;
            if (r_sens_s2 != r_sensor_db) begin
                if (r_db_cnt == DbLast) begin
                    r_sensor_db <= r_sens_s2;
                    r_db_rise   <= r_sens_s2;
                    r_db_cnt    <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    // Tick prescaler: held at zero outside the timing states so that the
    // first tick lands PRESCALE clocks after the frame start
    always_ff @(posedge i_clk27) begin
        if (i_reset || !w_run) begin
            r_presc <= '0;
        end else if (r_presc == PresLast) begin
            r_presc <= '0;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    // Test sequencing FSM with registered outputs and result counters
    always_ff @(posedge i_clk27) begin
        if (i_reset) begin
            r_state      <= StIdle;
            r_lat_cnt    <= '0;
            r_stb_cnt    <= '0;
            r_hold_cnt   <= '0;
            r_lt_active  <= 1'b0;
            r_lt_mode    <= 2'b00;
            r_done       <= 1'b0;
            r_timeout    <= 1'b0;
            r_result_lat <= '0;
            r_result_stb <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_abort && (r_state != StIdle)) begin
                r_state     <= StIdle;
                r_lt_active <= 1'b0;
            end else begin
                case (r_state)
                    StIdle: begin
                        // abort in the same cycle suppresses the start
                        if (i_start && !i_abort) begin
                            r_lt_mode    <= i_mode_in;
                            r_result_lat <= '0;
                            r_result_stb <= '0;
                            r_timeout    <= 1'b0;
                            r_state      <= StWaitVs;
                        end
                    end
                    StWaitVs: begin
                        if (w_frame_start) begin
                            r_lt_active <= 1'b1;
                            r_lat_cnt   <= '0;
                            r_state     <= StLat;
                        end
                    end
                    StLat: begin
                        if (r_db_rise) begin
                            r_result_lat <= r_lat_cnt;
                            r_stb_cnt    <= '0;
                            r_hold_cnt   <= '0;
                            r_state      <= StStb;
                        end else if (w_tick) begin
                            if (r_lat_cnt == CntNearMax) begin
                                r_lat_cnt    <= CntMax;
                                r_result_lat <= CntMax;
                                r_timeout    <= 1'b1;
                                r_state      <= StDone;
                            end else begin
                                r_lat_cnt <= r_lat_cnt + 1'b1;
                            end
                        end
                    end
                    StStb: begin
                        if (r_hold_cnt == StbWin) begin
                            // report when the final stable-high window began
                            r_result_stb <= r_stb_cnt - StbWin;
                            r_state      <= StDone;
                        end else begin
                            if (w_tick) begin
                                if (r_stb_cnt == CntNearMax) begin
                                    r_stb_cnt    <= CntMax;
                                    r_result_stb <= CntMax;
                                    r_timeout    <= 1'b1;
                                    r_state      <= StDone;
                                end else begin
                                    r_stb_cnt <= r_stb_cnt + 1'b1;
                                end
                            end
                            if (!r_sensor_db) begin
                                r_hold_cnt <= '0;
                            end else if (w_tick) begin
                                r_hold_cnt <= r_hold_cnt + 1'b1;
                            end
                        end
                    end
                    StDone: begin
                        r_lt_active <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= StIdle;
                    end
                    default: begin
                        r_state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lt_sequencer.sv
`timescale 1ns / 1ps
// Bench for lt_sequencer: a default instance (1 us ticks) and a small
// instance (PRESCALE=1, CNT_W=8) for saturation, driven by a sensor
// waveform given as toggle offsets counted from the frame-start edge.
module tb_lt_sequencer;

    localparam int P1 = 27;
    localparam int W1 = 500;
    localparam int P2 = 1;
    localparam int W2 = 20;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        vsync;
    logic        sensor;
    logic        start1, abort1, start2, abort2;
    logic [1:0]  mode1, mode2;
    logic        act1, busy1, done1, to1;
    logic [1:0]  lmode1;
    logic [15:0] lat1, stb1;
    logic        act2, busy2, done2, to2;
    logic [1:0]  lmode2;
    logic [7:0]  lat2, stb2;

    int errors = 0;
    int checks = 0;
    int n;
    int tog[$];
    int done1_cnt = 0;
    int done2_cnt = 0;

    always #5 clk = ~clk;

    lt_sequencer u_dut (
        .i_clk27      (clk),
        .i_reset      (reset),
        .i_start      (start1),
        .i_abort      (abort1),
        .i_mode_in    (mode1),
        .i_vsync_in   (vsync),
        .i_sensor_in  (sensor),
        .o_lt_active  (act1),
        .o_lt_mode    (lmode1),
        .o_busy       (busy1),
        .o_done       (done1),
        .o_timeout    (to1),
        .o_result_lat (lat1),
        .o_result_stb (stb1)
    );

    lt_sequencer #(
        .PRESCALE   (P2),
        .CNT_W      (8),
        .DEBOUNCE   (DB),
        .STB_WINDOW (W2)
    ) u_dut_s (
        .i_clk27      (clk),
        .i_reset      (reset),
        .i_start      (start2),
        .i_abort      (abort2),
        .i_mode_in    (mode2),
        .i_vsync_in   (vsync),
        .i_sensor_in  (sensor),
        .o_lt_active  (act2),
        .o_lt_mode    (lmode2),
        .o_busy       (busy2),
        .o_done       (done2),
        .o_timeout    (to2),
        .o_result_lat (lat2),
        .o_result_stb (stb2)
    );

    always @(negedge clk) begin
        if (done1) done1_cnt++;
        if (done2) done2_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Sensor level at offset t: parity of toggles at or before t
    function automatic logic lvl(input int t);
        int c;
        c = 0;
        foreach (tog[i]) if (tog[i] <= t) c++;
        return c[0];
    endfunction

    // Light sampled at offset k: debounced level settles 2+DEBOUNCE edges
    // later and the sequencer acts on it one edge after that. Ticks fall on
    // offsets that are positive multiples of the prescale.
    function automatic int exp_lat(input int k, input int p);
        return (k + 2 + DB) / p;
    endfunction

    // Ticks after latching the first light up to the final debounced rise
    function automatic int exp_stb(input int k, input int f, input int p);
        int cap;
        int r;
        cap = k + 3 + DB;
        r   = f + 2 + DB;
        if (r <= cap) return 0;
        return r / p - cap / p;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        n++;
        sensor = lvl(n);
    endtask

    task automatic steps(input int k);
        repeat (k) step();
    endtask

    task automatic quiet();
        tog.delete();
        n = -1000000;
        steps(20);
    endtask

    // Falling VSYNC; the following edge is offset 0
    task automatic frame();
        vsync = 1'b0;
        step();
        n = 0;
        sensor = lvl(0);
        vsync = 1'b1;
    endtask

    task automatic wait_done(input int which, input int budget, input string tag);
        int  k;
        bit  seen;
        k = 0;
        seen = 1'b0;
        while (!seen && k < budget) begin
            step();
            k++;
            seen = (which == 1) ? done1 : done2;
        end
        chk(tag, 32'(seen), 1);
    endtask

    initial begin
        int k, j, d0, a1, a2, a3, m;
        reset = 1'b1; vsync = 1'b1; sensor = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; mode1 = 2'd0;
        start2 = 1'b0; abort2 = 1'b0; mode2 = 2'd0;
        n = -1000000;
        steps(4);
        chk("rst_active", 32'(act1), 0);
        chk("rst_mode", 32'(lmode1), 0);
        chk("rst_busy", 32'(busy1), 0);
        chk("rst_done", 32'(done1), 0);
        chk("rst_timeout", 32'(to1), 0);
        chk("rst_lat", 32'(lat1), 0);
        chk("rst_stb", 32'(stb1), 0);
        chk("rst_busy_s", 32'(busy2), 0);
        reset = 1'b0;
        steps(2);

        // Clean rise 2700 clocks after the pattern appears
        quiet();
        start1 = 1'b1; mode1 = 2'd2; step(); start1 = 1'b0; mode1 = 2'd0;
        chk("t1_busy", 32'(busy1), 1);
        chk("t1_mode", 32'(lmode1), 2);
        steps(5);
        chk("t1_wait_inactive", 32'(act1), 0);
        tog.push_back(2700);
        frame();
        chk("t1_active", 32'(act1), 1);
        d0 = done1_cnt;
        wait_done(1, 2700 + W1 * P1 + 300, "t1_done");
        chk("t1_lat", 32'(lat1), 100);
        chk("t1_lat_model", 32'(lat1), exp_lat(2700, P1));
        chk("t1_stb", 32'(stb1), exp_stb(2700, 2700, P1));
        chk("t1_timeout", 32'(to1), 0);
        chk("t1_inactive", 32'(act1), 0);
        chk("t1_idle", 32'(busy1), 0);
        chk("t1_mode_held", 32'(lmode1), 2);
        steps(3);
        chk("t1_done_once", 32'(done1_cnt - d0), 1);

        // Three debounced dropouts over 5000 clocks, then stable light
        quiet();
        m = $urandom_range(0, 3);
        start1 = 1'b1; mode1 = 2'(m); step(); start1 = 1'b0;
        chk("t2_mode", 32'(lmode1), m);
        k  = $urandom_range(100, 600);
        a1 = k + 1000 + $urandom_range(0, 400);
        a2 = k + 2500 + $urandom_range(0, 400);
        a3 = k + 5000 - $urandom_range(10, 40);
        tog.push_back(k);
        tog.push_back(a1);
        tog.push_back(a1 + $urandom_range(10, 40));
        tog.push_back(a2);
        tog.push_back(a2 + $urandom_range(10, 40));
        tog.push_back(a3);
        tog.push_back(k + 5000);
        frame();
        d0 = done1_cnt;
        wait_done(1, k + 5000 + W1 * P1 + 300, "t2_done");
        chk("t2_lat", 32'(lat1), exp_lat(k, P1));
        chk("t2_stb", 32'(stb1), exp_stb(k, k + 5000, P1));
        chk("t2_stb_range", 32'((stb1 >= 16'd184) && (stb1 <= 16'd186)), 1);
        chk("t2_timeout", 32'(to1), 0);
        steps(3);
        chk("t2_done_once", 32'(done1_cnt - d0), 1);

        // Glitch of DEBOUNCE-1 clocks in LAT, then a real rise
        quiet();
        start1 = 1'b1; mode1 = 2'd1; step(); start1 = 1'b0;
        j = $urandom_range(50, 300);
        k = j + $urandom_range(100, 800);
        tog.push_back(j);
        tog.push_back(j + DB - 1);
        tog.push_back(k);
        frame();
        wait_done(1, k + W1 * P1 + 300, "t3_done");
        chk("t3_lat", 32'(lat1), exp_lat(k, P1));
        chk("t3_stb", 32'(stb1), 0);

        // No light on the small instance: latency counter saturates
        quiet();
        start2 = 1'b1; mode2 = 2'd1; step(); start2 = 1'b0;
        frame();
        chk("t4_active", 32'(act2), 1);
        wait_done(2, 400, "t4_done");
        chk("t4_when", 32'(n), 256);
        chk("t4_timeout", 32'(to2), 1);
        chk("t4_lat", 32'(lat2), 8'hFF);
        chk("t4_stb", 32'(stb2), 0);
        chk("t4_inactive", 32'(act2), 0);

        // Light flickers too fast to stabilise: stabilisation counter saturates
        quiet();
        start2 = 1'b1; step(); start2 = 1'b0;
        chk("t4b_timeout_clr", 32'(to2), 0);
        chk("t4b_lat_clr", 32'(lat2), 0);
        k = $urandom_range(5, 20);
        for (int i = 0; i < 50; i++) tog.push_back(k + 12 * i);
        frame();
        wait_done(2, 400, "t4b_done");
        chk("t4b_when", 32'(n), k + 3 + DB + 256);
        chk("t4b_timeout", 32'(to2), 1);
        chk("t4b_stb", 32'(stb2), 8'hFF);
        chk("t4b_lat", 32'(lat2), exp_lat(k, P2));

        // Abort: beats start in IDLE, and cancels a test in LAT
        quiet();
        start1 = 1'b1; abort1 = 1'b1; step(); start1 = 1'b0; abort1 = 1'b0;
        chk("t5_abort_beats_start", 32'(busy1), 0);
        start1 = 1'b1; mode1 = 2'd3; step(); start1 = 1'b0;
        frame();
        steps($urandom_range(10, 500));
        d0 = done1_cnt;
        abort1 = 1'b1; step(); abort1 = 1'b0;
        chk("t5_inactive", 32'(act1), 0);
        chk("t5_idle", 32'(busy1), 0);
        steps(5);
        chk("t5_no_done", 32'(done1_cnt - d0), 0);
        chk("t5_lat", 32'(lat1), 0);
        chk("t5_stb", 32'(stb1), 0);
        chk("t5_timeout", 32'(to1), 0);

        // Fresh start after abort; starts while busy are ignored; reset mid-STB
        quiet();
        start1 = 1'b1; mode1 = 2'd1; step(); start1 = 1'b0;
        steps(3);
        start1 = 1'b1; mode1 = 2'd2; step(); start1 = 1'b0;
        chk("t6_mode_wait", 32'(lmode1), 1);
        k = $urandom_range(100, 600);
        tog.push_back(k);
        frame();
        start1 = 1'b1; mode1 = 2'd3; step(); start1 = 1'b0;
        chk("t6_mode_lat", 32'(lmode1), 1);
        steps(k + 10);
        chk("t6_lat", 32'(lat1), exp_lat(k, P1));
        chk("t6_busy", 32'(busy1), 1);
        chk("t6_active", 32'(act1), 1);
        steps(200);
        reset = 1'b1; step(); reset = 1'b0;
        chk("t6_rst_active", 32'(act1), 0);
        chk("t6_rst_mode", 32'(lmode1), 0);
        chk("t6_rst_busy", 32'(busy1), 0);
        chk("t6_rst_timeout", 32'(to1), 0);
        chk("t6_rst_lat", 32'(lat1), 0);
        chk("t6_rst_stb", 32'(stb1), 0);
        steps(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
